dec_display_driver: RTL
=======================

# dec_display_driver

Parametrised binary-to-decimal 7-segment display driver: accepts an unsigned binary value over a valid/ready handshake and converts it to BCD sequentially (shift-add-3, one bit per clock). It holds the result and drives DIGITS active-low 7-segment outputs with leading-zero blanking, overflow indication and display enable. It sits between counter/datapath logic and the board HEX displays, and replaces the fixed two-digit decimal decoder.

## Interface
- DATA_W, 14: width of input value; legal 1..20.
- DIGITS, 4: number of displayed decimal digits; legal 1..8.
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_data  in  DATA_W  unsigned value to display.
- i_valid  in  1  i_data valid; transfer when i_valid && o_ready at an edge.
- o_ready  out  1  high exactly when FSM is IDLE (combinational from state).
- i_enable  in  1  0 = all digits off; held result retained.
- i_blank_lz  in  1  1 = blank leading zeros.
- o_dec_HEXs  out  [DIGITS-1:0] x 7  segment patterns, active-low, bit6 = g … bit0 = a; index 0 = least significant digit.
- o_overflow  out  1  held value exceeds 10^DIGITS-1.
- o_done  out  1  one-cycle pulse: new result visible on o_dec_HEXs.

## Operation
- Encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, off=1111111, dash=0111111.
- FSM: IDLE -> SHIFT on handshake; SHIFT -> UPDATE after DATA_W shift cycles; UPDATE -> IDLE unconditionally.
- Accept: capture i_data into shift register, clear internal BCD accumulator, load bit counter = DATA_W, set pending overflow flag = (i_data > 10^DIGITS-1), constant compare.
- SHIFT cycle: every BCD nibble >= 5 gets +3, then {BCD, data} shifted left by 1, MSB of data enters BCD bit0; counter decrements. Internal BCD width = 4*(ceil(DATA_W/3)+1) bits so no intermediate loss.
- UPDATE: low DIGITS nibbles -> result register; pending overflow -> result overflow flag.
- Display stage, registered every cycle from result register and mode inputs:
  - i_enable=0: all digits off.
  - else overflow: all digits dash.
  - else i_blank_lz=1: digits above the most significant nonzero digit off; value 0 shows "0" in digit 0 only.
  - else all digits shown including leading zeros.
- o_overflow registered with segments from result overflow flag, independent of i_enable.
- i_valid while not ready is ignored; input is not queued. i_data is sampled only at the handshake edge.

## Timing
- Reset (i_rst=1 at an edge): state IDLE, result=0, overflow flag=0, counter=0, o_dec_HEXs all off, o_overflow=0, o_done=0. i_valid ignored during reset. o_ready=1 from first cycle after reset. Next edge with i_rst=0 the display shows result 0 per mode ("0" or "0000").
- Reset mid-conversion aborts; the partial result is discarded.
- Handshake at edge E0. Shifts at E1..E_DATA_W. UPDATE at E_(DATA_W+1) loads result, state -> IDLE. Segments/o_overflow change at E_(DATA_W+2); o_done high for the cycle following E_(DATA_W+2).
- Latency handshake -> display = DATA_W+2 edges (16 for defaults). Minimum accept spacing = DATA_W+2 edges; a new handshake may coincide with o_done.
- i_enable/i_blank_lz changes reflected on segments at the next edge, with no effect on an ongoing conversion.

## Test plan
- Reset, then i_enable=1, i_blank_lz=0 -> HEX[3..0] = 0,0,0,0 patterns, o_overflow=0, o_ready=1, o_done=0.
- Send 1234 -> o_ready low for 15 cycles; at E16 HEX[3..0] = 1111001,0100100,0110000,0011001; o_done single pulse.
- Send 7 with i_blank_lz=1 -> HEX[3..1] = 1111111, HEX[0] = 1111000; toggle i_blank_lz=0 -> HEX[3..1] = 1000000 next edge, no o_done.
- Send 9999 then 10000 back-to-back (second valid held high) -> 9999 shown, then all dash with o_overflow=1; second accepted at E16 of the first; i_enable=0 -> all 1111111, o_overflow stays 1.
- Send 5678, assert i_rst at E8 -> no o_done, display returns to 0, next send 42 (DATA_W=14) -> correct "  42".
- Exhaustive sweep 0..16383 with random valid gaps -> each displayed value and o_overflow match a software reference.

Source files
------------

// File: rtl/dec_display_driver.sv
// -----------------------------------------------------------------------------
// dec_display_driver
//
// Converts an unsigned binary value into decimal digits and drives a row of
// active-low 7-segment displays. A value is accepted over a valid/ready
// handshake. It is then converted with a sequential shift-add-3 pass, one
// input bit per clock. The result is held and redrawn every cycle. The redraw
// uses the current enable and leading-zero-blanking inputs.
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_data      unsigned value to display (DATA_W bits)
//   i_valid     i_data valid; transfer when i_valid && o_ready at an edge
//   o_ready     high exactly while the converter is idle
//   i_enable    0 = all digits off (held result retained)
//   i_blank_lz  1 = blank leading zeros
//   o_dec_HEXs  DIGITS x 7 segment patterns, active-low, bit6=g .. bit0=a,
//               index 0 = least significant digit
//   o_overflow  held value does not fit in DIGITS decimal digits
//   o_done      one-cycle pulse when a new result appears on o_dec_HEXs
// -----------------------------------------------------------------------------
module dec_display_driver #(
    parameter int DATA_W = 14,
    parameter int DIGITS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_enable,
    input  logic                   i_blank_lz,
    output logic [DIGITS-1:0][6:0] o_dec_HEXs,
    output logic                   o_overflow,
    output logic                   o_done
);

    // One spare nibble beyond ceil(DATA_W/3) so the +3 correction never
    // carries out of the accumulator.
    localparam int NIB   = (DATA_W + 2) / 3 + 1;
    localparam int BCD_W = 4 * NIB;
    localparam int RES_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic longint unsigned max_shown(input int digits);
        longint unsigned v;
        v = 1;
        for (int k = 0; k < digits; k++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    localparam longint unsigned MAX_VAL = max_shown(DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_pend_q, ovf_pend_d;
    logic [RES_W-1:0]         result_q, result_d;
    logic                     res_ovf_q, res_ovf_d;
    logic                     upd_q, upd_d;
    logic [DIGITS-1:0][6:0]   hex_q, hex_d;
    logic                     ovf_out_q, ovf_out_d;
    logic                     done_q, done_d;

    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+DATA_W-1:0]  shifted;
    logic [RES_W-1:0]         bcd_res;
    logic [6:0]               dig_seg [DIGITS];

    genvar gi;

    // Add-3 correction on every nibble that would reach 10 or more after the shift
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        bcd_q[4*gi +: 4] + 4'd3 :
                                        bcd_q[4*gi +: 4];
        end
    endgenerate

    assign shifted = {bcd_adj, data_q} << 1;

    // Displayed digits; positions beyond the accumulator width read as zero
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_res
            if (gi < NIB) begin : g_take
                assign bcd_res[4*gi +: 4] = bcd_q[4*gi +: 4];
            end else begin : g_zero
                assign bcd_res[4*gi +: 4] = 4'd0;
            end
        end
    endgenerate

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            result_q   <= '0;
            res_ovf_q  <= 1'b0;
            upd_q      <= 1'b0;
            hex_q      <= '1;
            ovf_out_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            result_q   <= result_d;
            res_ovf_q  <= res_ovf_d;
            upd_q      <= upd_d;
            hex_q      <= hex_d;
            ovf_out_q  <= ovf_out_d;
            done_q     <= done_d;
        end
    end

    // Next-state and conversion datapath
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        result_d   = result_q;
        res_ovf_d  = res_ovf_q;
        upd_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d    = S_SHIFT;
                    data_d     = i_data;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(DATA_W);
                    ovf_pend_d = (64'(i_data) > MAX_VAL);
                end
            end
            S_SHIFT: begin
                bcd_d  = shifted[BCD_W+DATA_W-1 -: BCD_W];
                data_d = shifted[DATA_W-1:0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                result_d  = bcd_res;
                res_ovf_d = ovf_pend_q;
                upd_d     = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-digit display pattern. A digit is lit under blanking if it or any
    // more significant digit is nonzero; digit 0 is always lit so 0 shows "0".
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_disp
            logic [3:0] dig;
            logic       lead_nz;
            logic       shown;
            assign dig     = result_q[4*gi +: 4];
            assign lead_nz = |result_q[RES_W-1 : 4*gi];
            assign shown   = !i_blank_lz || (gi == 0) || lead_nz;
            assign dig_seg[gi] = !i_enable ? SEG_OFF  :
                                 res_ovf_q ? SEG_DASH :
                                 shown     ? seg7(dig) : SEG_OFF;
        end
    endgenerate

    always_comb begin
        hex_d = '1;
        for (int k = 0; k < DIGITS; k++) begin
            hex_d[k] = dig_seg[k];
        end
        ovf_out_d = res_ovf_q;
        done_d    = upd_q;
    end

    // Outputs
    always_comb begin
        o_ready    = (state_q == S_IDLE);
        o_dec_HEXs = hex_q;
        o_overflow = ovf_out_q;
        o_done     = done_q;
    end

endmodule
